// File: rtl/audio_data_play.sv
// Audio playback: parses radio frames, buffers good payloads, plays them out a 16-bit serial DAC.
// Ports: clk/reset, audio_mode gate, rx_* byte stream, AUDIO_DAC_* serial DAC,
//        pkt_accepted/pkt_dropped/underrun pulses, fifo_level, testpt.
// Optional: define AUDIO_PLAY_DSN_FILTER_EN to drop frames repeating the last committed DSN.

`ifndef AUDIO_PLAY
`define AUDIO_PLAY 1'b1
`endif

module audio_data_play #(
  parameter int DEPTH_LOG2 = 8,
  parameter int FS_DIV     = 2000,
  parameter int SCLK_DIV   = 4,
  parameter int PREFILL    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  audio_mode,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_done,
  input  logic                  rx_crc_ok,
  output logic                  AUDIO_DAC_SCLK,
  output logic                  AUDIO_DAC_CS,
  output logic                  AUDIO_DAC_SDATA,
  output logic                  pkt_accepted,
  output logic                  pkt_dropped,
  output logic                  underrun,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [7:0]            testpt
);

  localparam int AW = DEPTH_LOG2;
  localparam int LW = DEPTH_LOG2 + 1;
  localparam int CW = $clog2(FS_DIV);
  localparam int SW = $clog2(SCLK_DIV) + 1;

  localparam logic [LW-1:0] PRE    = LW'(PREFILL);
  localparam logic [CW-1:0] FS_TOP = CW'(FS_DIV - 1);
  localparam logic [SW-1:0] SC_TOP = SW'(SCLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_FCS,
    S_WAIT
  } pst_t;

  typedef enum logic [1:0] {
    SRC_MID,
    SRC_RAM,
    SRC_HOLD
  } src_t;

  // Leaving play mode holds the whole block in reset.
  logic rst;
  assign rst = reset || (audio_mode != `AUDIO_PLAY);

  // ---------------- parser / writer ----------------
  pst_t          st, st_n;
  logic [7:0]    len_q, len_n;
  logic [7:0]    idx_q, idx_n;
  logic [7:0]    dsn_q, dsn_n;
  logic          bad_q, bad_n;
  logic [LW-1:0] wr_stage, wrs_n;
  logic [LW-1:0] wr_commit, wrc_n;
  logic [LW-1:0] rd;
  logic          acc_n, drop_n;
  logic          we;
  logic          commit;
  logic          hdr_bad;
  logic          dup;
  logic [AW-1:0] wr_nx;
  logic          space;

  logic [7:0]    mem [2**AW];

`ifdef AUDIO_PLAY_DSN_FILTER_EN
  logic [7:0] last_dsn;
  logic       last_vld;
`endif

  assign wr_nx = wr_stage[AW-1:0] + AW'(1);
  // One slot stays free so a full stage never aliases rd.
  assign space = (wr_nx != rd[AW-1:0]);

  always_comb begin
    st_n    = st;
    len_n   = len_q;
    idx_n   = idx_q;
    dsn_n   = dsn_q;
    bad_n   = bad_q;
    wrs_n   = wr_stage;
    wrc_n   = wr_commit;
    acc_n   = 1'b0;
    drop_n  = 1'b0;
    we      = 1'b0;
    commit  = 1'b0;
    hdr_bad = 1'b0;
    dup     = 1'b0;

    if (rx_valid) begin
      unique case (st)
        S_IDLE: begin
          len_n = rx_data;
          idx_n = 8'd1;
          bad_n = (rx_data < 8'd11) ||
                  (rx_data > 8'd127);
          st_n  = S_HDR;
        end
        S_HDR: begin
          idx_n = idx_q + 8'd1;
          unique case (idx_q)
            8'd1: hdr_bad = (rx_data != 8'hc1);
            8'd2: hdr_bad = (rx_data != 8'h88);
            8'd3: dsn_n   = rx_data;
            8'd4: hdr_bad = (rx_data != 8'h22);
            8'd5: hdr_bad = (rx_data != 8'h00);
            8'd6: hdr_bad = (rx_data != 8'hfe);
            8'd7: hdr_bad = (rx_data != 8'hff);
            default: hdr_bad = 1'b0;
          endcase
          if (hdr_bad) bad_n = 1'b1;
          if (idx_q == 8'd9) begin
            st_n = (len_q == 8'd11) ? S_FCS : S_PAY;
          end
        end
        S_PAY: begin
          idx_n = idx_q + 8'd1;
          if (!bad_q && space) begin
            we    = 1'b1;
            wrs_n = wr_stage + LW'(1);
          end else begin
            bad_n = 1'b1;
          end
          if (idx_q == len_q - 8'd2) st_n = S_FCS;
        end
        S_FCS: begin
          idx_n = idx_q + 8'd1;
          if (idx_q == len_q) st_n = S_WAIT;
        end
        default: begin
        end
      endcase
    end

`ifdef AUDIO_PLAY_DSN_FILTER_EN
    dup = last_vld && (dsn_n == last_dsn);
`endif

    // Done sees the state after any same-cycle byte.
    if (rx_done && st_n != S_IDLE) begin
      if (st_n == S_WAIT && rx_crc_ok &&
          !bad_n && !dup) begin
        wrc_n  = wrs_n;
        acc_n  = 1'b1;
        commit = 1'b1;
      end else begin
        wrs_n  = wr_commit;
        drop_n = 1'b1;
      end
      st_n = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= S_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      dsn_q        <= '0;
      bad_q        <= 1'b0;
      wr_stage     <= '0;
      wr_commit    <= '0;
      pkt_accepted <= 1'b0;
      pkt_dropped  <= 1'b0;
    end else begin
      st           <= st_n;
      len_q        <= len_n;
      idx_q        <= idx_n;
      dsn_q        <= dsn_n;
      bad_q        <= bad_n;
      wr_stage     <= wrs_n;
      wr_commit    <= wrc_n;
      pkt_accepted <= acc_n;
      pkt_dropped  <= drop_n;
    end
  end

`ifdef AUDIO_PLAY_DSN_FILTER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dsn <= '0;
      last_vld <= 1'b0;
    end else if (commit) begin
      last_dsn <= dsn_n;
      last_vld <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_stage[AW-1:0]] <= rx_data;
  end

  assign fifo_level = wr_commit - rd;

  // ---------------- sample clock / reader ----------------
  logic [CW-1:0] cnt;
  logic          tick;
  logic          playing;
  logic          start;
  logic          play;
  logic          play_go, und_go, mid_go;
  src_t          src_q;
  logic          ld_q;
  logic [7:0]    ram_q;
  logic [15:0]   last_sample;
  logic [15:0]   word;

  assign tick    = (cnt == '0);
  assign start   = !playing && (fifo_level >= PRE);
  assign play    = playing || start;
  assign play_go = tick && play && (fifo_level != '0);
  assign und_go  = tick && play && (fifo_level == '0);
  assign mid_go  = tick && !play;

  always_ff @(posedge clk) begin
    if (tick) ram_q <= mem[rd[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= FS_TOP;
      rd          <= '0;
      playing     <= 1'b0;
      underrun    <= 1'b0;
      src_q       <= SRC_MID;
      ld_q        <= 1'b0;
      last_sample <= 16'h8000;
    end else begin
      underrun <= 1'b0;
      ld_q     <= tick;
      cnt      <= tick ? FS_TOP : cnt - CW'(1);
      unique case (1'b1)
        play_go: begin
          rd      <= rd + LW'(1);
          playing <= 1'b1;
          src_q   <= SRC_RAM;
        end
        und_go: begin
          playing  <= 1'b0;
          underrun <= 1'b1;
          src_q    <= SRC_HOLD;
        end
        mid_go: src_q <= SRC_MID;
        default: begin
        end
      endcase
      if (ld_q && src_q == SRC_RAM) begin
        last_sample <= {ram_q, 8'h00};
      end
    end
  end

  // Word is picked the cycle after the tick, once RAM data is out.
  always_comb begin
    word = 16'h8000;
    unique case (src_q)
      SRC_RAM:  word = {ram_q, 8'h00};
      SRC_HOLD: word = last_sample;
      default:  word = 16'h8000;
    endcase
  end

  // ---------------- DAC serializer ----------------
  logic          busy;
  logic [15:0]   sh;
  logic [5:0]    hc;
  logic [SW-1:0] dv;

  always_ff @(posedge clk) begin
    if (rst) begin
      AUDIO_DAC_SCLK  <= 1'b0;
      AUDIO_DAC_CS    <= 1'b1;
      AUDIO_DAC_SDATA <= 1'b0;
      busy            <= 1'b0;
      sh              <= '0;
      hc              <= '0;
      dv              <= '0;
    end else if (ld_q) begin
      AUDIO_DAC_CS    <= 1'b0;
      AUDIO_DAC_SCLK  <= 1'b0;
      AUDIO_DAC_SDATA <= word[15];
      sh              <= word;
      busy            <= 1'b1;
      hc              <= '0;
      dv              <= SC_TOP;
    end else if (busy) begin
      if (dv != '0) begin
        dv <= dv - SW'(1);
      end else begin
        dv <= SC_TOP;
        // 32 half-periods, then one more for CS hold.
        if (hc == 6'd32) begin
          AUDIO_DAC_CS <= 1'b1;
          busy         <= 1'b0;
        end else begin
          AUDIO_DAC_SCLK <= ~AUDIO_DAC_SCLK;
          hc             <= hc + 6'd1;
          if (AUDIO_DAC_SCLK) begin
            sh <= {sh[14:0], 1'b0};
            AUDIO_DAC_SDATA <=
              (hc == 6'd31) ? 1'b0 : sh[14];
          end
        end
      end
    end
  end

  assign testpt = {rx_valid, rx_done, audio_mode,
                   playing, underrun, pkt_accepted,
                   pkt_dropped, AUDIO_DAC_CS};

endmodule
